// File: rtl/tx_flow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tx_flow_pkg
// Shared definitions for the PCIe transmit-layer flow controller:
//   - link FSM state encoding (the codes are visible on the `state` port)
//   - default widths and the routing bit position inside a FIFO word
//   - bit positions inside the err_in bus
// ---------------------------------------------------------------------------
package tx_flow_pkg;

  localparam int TX_DATA_WIDTH   = 6;
  localparam int TX_UMBRAL_WIDTH = 4;

  // The word MSB selects the destination FIFO: 0 -> D0, 1 -> D1.
  localparam int DEST_BIT = TX_DATA_WIDTH - 1;

  // Number of virtual-channel source FIFOs; lower index has higher priority.
  localparam int NUM_VC = 2;

  // err_in = {d1, d0, vc1, vc0}
  localparam int ERR_VC0   = 0;
  localparam int ERR_VC1   = 1;
  localparam int ERR_D0    = 2;
  localparam int ERR_D1    = 3;
  localparam int ERR_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } tx_state_e;

  // Routing bit for an arbitrary word width.
  function automatic int dest_bit(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/tx_flow_ctrl_if.sv
// ---------------------------------------------------------------------------
// tx_flow_ctrl_if
// FIFO-side bus of the transmit flow controller.
//   VC side : vc0/vc1 empty flags and data_out (in), rd enables (out)
//   D side  : d0/d1 full and almost-full flags (in), wr enables and shared
//             d_data (out)
// modport master : controller view
// modport slave  : FIFO chain view
// ---------------------------------------------------------------------------
interface tx_flow_ctrl_if
  import tx_flow_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH
) ();

  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [DATA_WIDTH-1:0] vc0_data;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  vc0_rd;
  logic                  vc1_rd;

  logic                  d0_full;
  logic                  d1_full;
  logic                  d0_almost_full;
  logic                  d1_almost_full;
  logic                  d0_wr;
  logic                  d1_wr;
  logic [DATA_WIDTH-1:0] d_data;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data,
    input  d0_full, d1_full, d0_almost_full, d1_almost_full,
    output vc0_rd, vc1_rd, d0_wr, d1_wr, d_data
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data,
    output d0_full, d1_full, d0_almost_full, d1_almost_full,
    input  vc0_rd, vc1_rd, d0_wr, d1_wr, d_data
  );

endinterface

// File: rtl/tx_flow_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// tx_vc_arbiter
// Strict-priority VC pop arbiter plus the two-stage pop/route pipeline.
//   clk, reset : clock, synchronous active-low reset
//   pop_en     : 1 while the link is ACTIVE (pops allowed)
//   wr_en      : 1 while IDLE/ACTIVE; 0 drops everything in flight
//   fifo_bus   : FIFO chain (master view)
//   busy       : a word sits in stage 1 or stage 2
// Timeline for a word popped in cycle N:
//   N   : vcX_rd=1, stage 1 records which VC was read
//   N+1 : vcX_data is valid, captured into d_data, MSB picks D0/D1
//   N+2 : d0_wr or d1_wr for one cycle
// ---------------------------------------------------------------------------
module tx_vc_arbiter
  import tx_flow_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pop_en,
  input  logic           wr_en,
  tx_flow_ctrl_if.master fifo_bus,
  output logic           busy
);

  localparam int DEST_IDX = dest_bit(DATA_WIDTH);

  logic [NUM_VC-1:0]     vc_empty;
  logic [NUM_VC-1:0]     grant;
  logic [DATA_WIDTH-1:0] vc_data [NUM_VC];
  logic                  room;
  logic [DATA_WIDTH-1:0] s1_word;

  logic                  s1_valid_reg, s1_valid_next;
  logic                  s1_src_reg,   s1_src_next;
  logic                  s2_valid_reg, s2_valid_next;
  logic                  s2_dest_reg,  s2_dest_next;
  logic [DATA_WIDTH-1:0] d_data_reg,   d_data_next;

  assign vc_empty   = {fifo_bus.vc1_empty, fifo_bus.vc0_empty};
  assign vc_data[0] = fifo_bus.vc0_data;
  assign vc_data[1] = fifo_bus.vc1_data;

  // The destination of a word is unknown until its data arrives, so a pop
  // requires headroom in both destinations. Almost-full leaves room for the
  // (at most two) words already in flight.
  assign room = pop_en
              & ~(fifo_bus.d0_full | fifo_bus.d1_full
                | fifo_bus.d0_almost_full | fifo_bus.d1_almost_full);

  // Strict priority: a VC is granted only when every lower-indexed VC is empty.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_grant
      if (gi == 0) begin : g_first
        assign grant[gi] = room & ~vc_empty[gi];
      end else begin : g_rest
        assign grant[gi] = room & ~vc_empty[gi] & (&vc_empty[gi-1:0]);
      end
    end
  endgenerate

  assign s1_word = vc_data[s1_src_reg];

  always_comb begin
    s1_valid_next = |grant;
    s1_src_next   = grant[1];
    s2_valid_next = s1_valid_reg;
    s2_dest_next  = s2_dest_reg;
    d_data_next   = d_data_reg;

    if (s1_valid_reg) begin
      d_data_next  = s1_word;
      s2_dest_next = s1_word[DEST_IDX];
    end

    // Leaving IDLE/ACTIVE (re-init or error): in-flight words are discarded
    // and d_data keeps its previous value.
    if (!wr_en) begin
      s1_valid_next = 1'b0;
      s2_valid_next = 1'b0;
      s2_dest_next  = s2_dest_reg;
      d_data_next   = d_data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s1_src_reg   <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_dest_reg  <= 1'b0;
      d_data_reg   <= '0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s1_src_reg   <= s1_src_next;
      s2_valid_reg <= s2_valid_next;
      s2_dest_reg  <= s2_dest_next;
      d_data_reg   <= d_data_next;
    end
  end

  assign fifo_bus.vc0_rd = grant[0];
  assign fifo_bus.vc1_rd = grant[1];
  assign fifo_bus.d0_wr  = wr_en & s2_valid_reg & ~s2_dest_reg;
  assign fifo_bus.d1_wr  = wr_en & s2_valid_reg &  s2_dest_reg;
  assign fifo_bus.d_data = d_data_reg;

  assign busy = s1_valid_reg | s2_valid_reg;

endmodule

// File: rtl/tx_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tx_flow_ctrl
// Sequencing and arbitration controller for the PCIe transmit FIFO chain.
//   clk, reset            : clock, synchronous active-low reset
//   init_req              : 1 requests (re)configuration, holds INIT
//   umbral_*_in / umbral_*: thresholds, latched every INIT cycle
//   fifo_init             : init to all FIFOs (0 = hold cleared)
//   fifo_bus              : VC/D FIFO handshakes (master view)
//   err_in                : {d1, d0, vc1, vc0} error flags
//   state                 : current FSM state code
//   idle                  : IDLE with nothing in flight
//   error_out             : sticky error (ERROR until reset)
// ---------------------------------------------------------------------------
module tx_flow_ctrl
  import tx_flow_pkg::*;
#(
  parameter int DATA_WIDTH   = TX_DATA_WIDTH,
  parameter int UMBRAL_WIDTH = TX_UMBRAL_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_req,
  input  logic [UMBRAL_WIDTH-1:0] umbral_main_in,
  input  logic [UMBRAL_WIDTH-1:0] umbral_vc_in,
  input  logic [UMBRAL_WIDTH-1:0] umbral_d_in,
  output logic [UMBRAL_WIDTH-1:0] umbral_main,
  output logic [UMBRAL_WIDTH-1:0] umbral_vc,
  output logic [UMBRAL_WIDTH-1:0] umbral_d,
  output logic                    fifo_init,
  tx_flow_ctrl_if.master          fifo_bus,
  input  logic [ERR_WIDTH-1:0]    err_in,
  output logic [2:0]              state,
  output logic                    idle,
  output logic                    error_out
);

  tx_state_e state_reg, state_next;

  logic [UMBRAL_WIDTH-1:0] umbral_main_reg;
  logic [UMBRAL_WIDTH-1:0] umbral_vc_reg;
  logic [UMBRAL_WIDTH-1:0] umbral_d_reg;

  logic err_any;
  logic vc_pending;
  logic busy;
  logic pop_en;
  logic wr_en;

  assign err_any    = err_in[ERR_VC0] | err_in[ERR_VC1]
                    | err_in[ERR_D0]  | err_in[ERR_D1];
  assign vc_pending = ~fifo_bus.vc0_empty | ~fifo_bus.vc1_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs. Errors are checked before init_req
  // so that a simultaneous request cannot mask an error.
  always_comb begin
    state_next = state_reg;
    fifo_init  = 1'b0;
    pop_en     = 1'b0;
    wr_en      = 1'b0;
    idle       = 1'b0;
    error_out  = 1'b0;

    case (state_reg)
      ST_RESET: begin
        state_next = ST_INIT;
      end

      ST_INIT: begin
        if (!init_req) state_next = ST_IDLE;
      end

      ST_IDLE: begin
        fifo_init = 1'b1;
        wr_en     = 1'b1;
        idle      = ~busy;
        if (err_any)         state_next = ST_ERROR;
        else if (init_req)   state_next = ST_INIT;
        else if (vc_pending) state_next = ST_ACTIVE;
      end

      ST_ACTIVE: begin
        fifo_init = 1'b1;
        pop_en    = 1'b1;
        wr_en     = 1'b1;
        if (err_any)                    state_next = ST_ERROR;
        else if (init_req)              state_next = ST_INIT;
        else if (!vc_pending && !busy)  state_next = ST_IDLE;
      end

      ST_ERROR: begin
        // FIFOs are left configured so their contents survive for debug;
        // all traffic stops and only reset leaves this state.
        fifo_init = 1'b1;
        error_out = 1'b1;
      end

      default: begin
        state_next = ST_ERROR;
      end
    endcase
  end

  // Thresholds track the inputs for as long as the link sits in INIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      umbral_main_reg <= '0;
      umbral_vc_reg   <= '0;
      umbral_d_reg    <= '0;
    end else if (state_reg == ST_INIT) begin
      umbral_main_reg <= umbral_main_in;
      umbral_vc_reg   <= umbral_vc_in;
      umbral_d_reg    <= umbral_d_in;
    end
  end

  assign umbral_main = umbral_main_reg;
  assign umbral_vc   = umbral_vc_reg;
  assign umbral_d    = umbral_d_reg;
  assign state       = state_reg;

  tx_vc_arbiter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_arbiter (
    .clk      (clk),
    .reset    (reset),
    .pop_en   (pop_en),
    .wr_en    (wr_en),
    .fifo_bus (fifo_bus),
    .busy     (busy)
  );

endmodule

// File: tb/tb_tx_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tx_flow_ctrl
// Directed bench for tx_flow_ctrl. The VC FIFOs are queues inside the bench;
// destination flags are driven directly. A cycle-level reference model,
// built from the link rules (state transitions, pop eligibility, priority,
// two-cycle pop-to-write latency, drops on re-init/error), is compared with
// the DUT on every falling edge. Literal expectations per scenario pin the
// model down.
// ---------------------------------------------------------------------------
module tb_tx_flow_ctrl;
  import tx_flow_pkg::*;

  localparam int DW = 6;
  localparam int UW = 4;

  localparam int S_RESET  = 0;
  localparam int S_INIT   = 1;
  localparam int S_IDLE   = 2;
  localparam int S_ACTIVE = 3;
  localparam int S_ERROR  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_req;
  logic [UW-1:0] umbral_main_in, umbral_vc_in, umbral_d_in;
  logic [UW-1:0] umbral_main, umbral_vc, umbral_d;
  logic          fifo_init;
  logic [3:0]    err_in;
  logic [2:0]    state;
  logic          idle;
  logic          error_out;

  tx_flow_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  tx_flow_ctrl #(
    .DATA_WIDTH   (DW),
    .UMBRAL_WIDTH (UW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init_req       (init_req),
    .umbral_main_in (umbral_main_in),
    .umbral_vc_in   (umbral_vc_in),
    .umbral_d_in    (umbral_d_in),
    .umbral_main    (umbral_main),
    .umbral_vc      (umbral_vc),
    .umbral_d       (umbral_d),
    .fifo_init      (fifo_init),
    .fifo_bus       (bus),
    .err_in         (err_in),
    .state          (state),
    .idle           (idle),
    .error_out      (error_out)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Bench-side VC FIFO contents and the log of observed destination writes.
  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];
  logic [DW-1:0] log_data[$];
  int            log_dest[$];

  // ---------------- reference model + per-cycle compare ----------------
  int            m_state = S_RESET;
  bit            live = 1'b0;
  logic [UW-1:0] m_um_main = '0, m_um_vc = '0, m_um_d = '0;
  bit            h1_v = 1'b0, h2_v = 1'b0;   // words popped 1 and 2 cycles ago
  logic [DW-1:0] h1_w = '0, h2_w = '0;

  always @(negedge clk) begin
    bit            room, pop0, pop1, wr_ok, exp_wr0, exp_wr1, vcs_empty;
    logic [DW-1:0] w;
    int            nxt;

    vcs_empty = (vc0_q.size() == 0) && (vc1_q.size() == 0);
    room  = (m_state == S_ACTIVE) && !(bus.d0_full || bus.d1_full ||
             bus.d0_almost_full || bus.d1_almost_full);
    pop0  = room && (vc0_q.size() != 0);
    pop1  = room && (vc0_q.size() == 0) && (vc1_q.size() != 0);
    wr_ok = (m_state == S_IDLE) || (m_state == S_ACTIVE);
    exp_wr0 = wr_ok && h2_v && !h2_w[DEST_BIT];
    exp_wr1 = wr_ok && h2_v &&  h2_w[DEST_BIT];

    if (live) begin
      check("state",     state, m_state);
      check("vc0_rd",    bus.vc0_rd, pop0);
      check("vc1_rd",    bus.vc1_rd, pop1);
      check("d0_wr",     bus.d0_wr, exp_wr0);
      check("d1_wr",     bus.d1_wr, exp_wr1);
      check("idle",      idle, (m_state == S_IDLE) && !h1_v && !h2_v);
      check("error_out", error_out, m_state == S_ERROR);
      if (m_state != S_ERROR)
        check("fifo_init", fifo_init, (m_state == S_IDLE) || (m_state == S_ACTIVE));
      check("umbral_main", umbral_main, m_um_main);
      check("umbral_vc",   umbral_vc, m_um_vc);
      check("umbral_d",    umbral_d, m_um_d);
      if (exp_wr0 || exp_wr1) check("d_data", bus.d_data, h2_w);
    end

    if (bus.d0_wr === 1'b1) begin
      log_data.push_back(bus.d_data); log_dest.push_back(0);
      $display("write d0 data=%b t=%0t", bus.d_data, $time);
    end
    if (bus.d1_wr === 1'b1) begin
      log_data.push_back(bus.d_data); log_dest.push_back(1);
      $display("write d1 data=%b t=%0t", bus.d_data, $time);
    end

    // Advance the model to the state after the coming rising edge.
    if (!reset) begin
      m_state = S_RESET;
      m_um_main = '0; m_um_vc = '0; m_um_d = '0;
      h1_v = 1'b0; h2_v = 1'b0;
      live = 1'b1;
    end else if (live) begin
      nxt = m_state;
      case (m_state)
        S_RESET:  nxt = S_INIT;
        S_INIT:   nxt = init_req ? S_INIT : S_IDLE;
        S_IDLE:   if (err_in != 0) nxt = S_ERROR;
                  else if (init_req) nxt = S_INIT;
                  else if (!vcs_empty) nxt = S_ACTIVE;
        S_ACTIVE: if (err_in != 0) nxt = S_ERROR;
                  else if (init_req) nxt = S_INIT;
                  else if (vcs_empty && !h1_v && !h2_v) nxt = S_IDLE;
        default:  nxt = S_ERROR;
      endcase
      if (m_state == S_INIT) begin
        m_um_main = umbral_main_in; m_um_vc = umbral_vc_in; m_um_d = umbral_d_in;
      end
      if (wr_ok) begin
        w = pop0 ? vc0_q[0] : vc1_q[0];
        h2_v = h1_v; h2_w = h1_w;
        h1_v = pop0 || pop1;
        if (pop0 || pop1) h1_w = w;
      end else begin
        h1_v = 1'b0; h2_v = 1'b0;
      end
      m_state = nxt;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      logic r0, r1;
      @(negedge clk);
      r0 = bus.vc0_rd;
      r1 = bus.vc1_rd;
      @(posedge clk);
      #1;
      if (r0 === 1'b1 && vc0_q.size() != 0) bus.vc0_data = vc0_q.pop_front();
      if (r1 === 1'b1 && vc1_q.size() != 0) bus.vc1_data = vc1_q.pop_front();
      bus.vc0_empty = (vc0_q.size() == 0);
      bus.vc1_empty = (vc1_q.size() == 0);
    end
  endtask

  task automatic push_vc(input int vc, input logic [DW-1:0] w);
    if (vc == 0) begin vc0_q.push_back(w); bus.vc0_empty = 1'b0; end
    else         begin vc1_q.push_back(w); bus.vc1_empty = 1'b0; end
  endtask

  task automatic set_umbral(input logic [UW-1:0] m, input logic [UW-1:0] v, input logic [UW-1:0] d);
    umbral_main_in = m; umbral_vc_in = v; umbral_d_in = d;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    reset = 1'b0; init_req = 1'b0; err_in = 4'b0;
    set_umbral(4'd0, 4'd0, 4'd0);
    bus.vc0_empty = 1'b1; bus.vc1_empty = 1'b1;
    bus.vc0_data = '0; bus.vc1_data = '0;
    bus.d0_full = 1'b0; bus.d1_full = 1'b0;
    bus.d0_almost_full = 1'b0; bus.d1_almost_full = 1'b0;

    // Reset then init.
    tick(2);
    check("rst_state", state, S_RESET);
    check("rst_fifo_init", fifo_init, 0);
    check("rst_d_data", bus.d_data, 0);
    reset = 1'b1; init_req = 1'b1; set_umbral(4'd3, 4'd3, 4'd3);
    tick(1);
    check("init_state", state, S_INIT);
    check("init_umbral_before_latch", umbral_main, 0);
    tick(2);
    check("init_umbral_main", umbral_main, 3);
    init_req = 1'b0;
    tick(1);
    check("idle_state", state, S_IDLE);
    check("idle_fifo_init", fifo_init, 1);
    check("idle_flag", idle, 1);
    check("idle_umbral_vc", umbral_vc, 3);
    check("idle_umbral_d", umbral_d, 3);

    // Single word routed to D1.
    base = log_data.size();
    push_vc(0, 6'b100101);
    tick(6);
    check("single_count", log_data.size() - base, 1);
    check("single_dest", log_dest[base], 1);
    check("single_data", log_data[base], 6'b100101);
    check("single_hold", bus.d_data, 6'b100101);
    check("single_back_idle", state, S_IDLE);

    // VC0 priority, back-to-back pops.
    base = log_data.size();
    push_vc(0, 6'b000011); push_vc(0, 6'b100110); push_vc(1, 6'b010101);
    tick(9);
    check("prio_count", log_data.size() - base, 3);
    check("prio_w0", log_data[base],   6'b000011);
    check("prio_w1", log_data[base+1], 6'b100110);
    check("prio_w2", log_data[base+2], 6'b010101);
    check("prio_dest", {log_dest[base][0], log_dest[base+1][0], log_dest[base+2][0]}, 3'b010);

    // Backpressure from D0 almost-full.
    base = log_data.size();
    bus.d0_almost_full = 1'b1;
    push_vc(0, 6'b001001); push_vc(1, 6'b101010);
    tick(4);
    check("bp_state", state, S_ACTIVE);
    check("bp_no_write", log_data.size() - base, 0);
    check("bp_no_pop", vc0_q.size() + vc1_q.size(), 2);
    bus.d0_almost_full = 1'b0;
    tick(7);
    check("bp_count", log_data.size() - base, 2);
    check("bp_w0", log_data[base],   6'b001001);
    check("bp_w1", log_data[base+1], 6'b101010);
    check("bp_idle", state, S_IDLE);

    // Error with a word in flight.
    base = log_data.size();
    push_vc(0, 6'b000111);
    tick(2);
    err_in = 4'b0100;
    tick(1);
    err_in = 4'b0000;
    check("err_state", state, S_ERROR);
    check("err_out", error_out, 1);
    tick(3);
    init_req = 1'b1;
    tick(2);
    init_req = 1'b0;
    check("err_sticky", state, S_ERROR);
    check("err_write_dropped", log_data.size() - base, 0);
    reset = 1'b0;
    tick(1);
    check("err_reset_state", state, S_RESET);
    check("err_reset_out", error_out, 0);
    reset = 1'b1; init_req = 1'b1; set_umbral(4'd5, 4'd6, 4'd7);
    tick(2);
    init_req = 1'b0;
    tick(1);
    check("reinit_idle", state, S_IDLE);
    check("reinit_umbral", {umbral_main, umbral_vc, umbral_d}, 12'h567);

    // Re-init in the middle of a transfer.
    base = log_data.size();
    push_vc(0, 6'b100001); push_vc(0, 6'b000010);
    tick(1);
    check("mid_active", state, S_ACTIVE);
    init_req = 1'b1; set_umbral(4'd9, 4'd10, 4'd11);
    tick(1);
    check("mid_init", state, S_INIT);
    check("mid_fifo_init", fifo_init, 0);
    tick(1);
    check("mid_umbral", {umbral_main, umbral_vc, umbral_d}, 12'h9AB);
    init_req = 1'b0;
    tick(8);
    check("mid_count", log_data.size() - base, 1);
    check("mid_survivor", log_data[base], 6'b000010);
    check("mid_dest", log_dest[base], 0);
    check("mid_idle", state, S_IDLE);

    // Error and init_req together: error takes precedence.
    init_req = 1'b1; err_in = 4'b0001;
    tick(1);
    init_req = 1'b0; err_in = 4'b0000;
    check("both_state", state, S_ERROR);
    tick(2);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
